// File: rtl/vc_port_scheduler.sv
// vc_port_scheduler
//
// Per-port output scheduler for the four PCIe transaction-layer VC FIFOs
// (VC0/VC1 of port 0 and port 1). Each port independently picks one FIFO
// to pop per cycle using weighted round-robin between VC0 and VC1, gates
// pops with its downstream stall, and forwards the popped word two cycles
// later tagged with its VC.
//
// Parameters:
//   W0 - VC0 burst weight, max consecutive VC0 grants per port (1..15)
//   W1 - VC1 burst weight (1..15)
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   empty_vcX_pY                  - FIFO empty flags
//   fifo_vcX_pY [4:0]             - FIFO read data (valid one cycle after pop)
//   fvalid_vcX_pY                 - FIFO read-data valid
//   stall_p0, stall_p1            - downstream stall per port
//   pop_vcX_pY                    - FIFO pop strobes (combinational)
//   out_p0, out_p1 [5:0]          - {vc_tag, data[4:0]}, registered
//   out_valid_p0, out_valid_p1    - output word valid
//   sched_err                     - sticky: pending word met fvalid = 0
//   grant_cnt [31:0]              - {vc1_p1, vc0_p1, vc1_p0, vc0_p0} grant counts
//
// Build option:
//   SCHED_GRANT_CNT_EN - when defined, grant_cnt holds four 8-bit saturating
//                        pop counters; otherwise grant_cnt is tied to zero.

module vc_port_scheduler #(
   parameter int unsigned W0 = 3,
   parameter int unsigned W1 = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        empty_vc0_p0,
   input  logic        empty_vc1_p0,
   input  logic        empty_vc0_p1,
   input  logic        empty_vc1_p1,
   input  logic [4:0]  fifo_vc0_p0,
   input  logic [4:0]  fifo_vc1_p0,
   input  logic [4:0]  fifo_vc0_p1,
   input  logic [4:0]  fifo_vc1_p1,
   input  logic        fvalid_vc0_p0,
   input  logic        fvalid_vc1_p0,
   input  logic        fvalid_vc0_p1,
   input  logic        fvalid_vc1_p1,
   input  logic        stall_p0,
   input  logic        stall_p1,
   output logic        pop_vc0_p0,
   output logic        pop_vc1_p0,
   output logic        pop_vc0_p1,
   output logic        pop_vc1_p1,
   output logic [5:0]  out_p0,
   output logic [5:0]  out_p1,
   output logic        out_valid_p0,
   output logic        out_valid_p1,
   output logic        sched_err,
   output logic [31:0] grant_cnt
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_VC0 = 2'd1,
      OWN_VC1 = 2'd2
   } state_t;

   localparam logic [3:0] WGT0 = W0[3:0];
   localparam logic [3:0] WGT1 = W1[3:0];

   // Per-port views of the FIFO bank, indexed by port number.
   logic [1:0] empty0, empty1;
   logic [1:0] fvalid0, fvalid1;
   logic [1:0] stall;
   logic [4:0] data0 [2];
   logic [4:0] data1 [2];

   assign empty0  = {empty_vc0_p1, empty_vc0_p0};
   assign empty1  = {empty_vc1_p1, empty_vc1_p0};
   assign fvalid0 = {fvalid_vc0_p1, fvalid_vc0_p0};
   assign fvalid1 = {fvalid_vc1_p1, fvalid_vc1_p0};
   assign stall   = {stall_p1, stall_p0};
   assign data0[0] = fifo_vc0_p0;
   assign data0[1] = fifo_vc0_p1;
   assign data1[0] = fifo_vc1_p0;
   assign data1[1] = fifo_vc1_p1;

   // Scheduler state
   state_t     state      [2];
   state_t     state_nxt  [2];
   logic [3:0] credit     [2];
   logic [3:0] credit_nxt [2];
   logic [1:0] pop0, pop1;

   // Owner-relative views: "c" is the owning VC, "o" the other one.
   logic [1:0] own1;
   logic [1:0] emp_c, emp_o;
   logic [3:0] wgt_c [2];

   // Output pipeline
   logic [1:0] pend;
   logic [1:0] vc_d;
   logic [1:0] out_v;
   logic [5:0] out_q [2];
   logic       err_q;

   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         own1[p]  = (state[p] == OWN_VC1);
         emp_c[p] = own1[p] ? empty1[p] : empty0[p];
         emp_o[p] = own1[p] ? empty0[p] : empty1[p];
         wgt_c[p] = own1[p] ? WGT1 : WGT0;
      end
   end

   // Pop decision and next state. Pops depend only on registered state,
   // the empty flags and stall, so a stall removes the pop in the same cycle.
   always_comb begin
      for (int unsigned p = 0; p < 2; p++) begin
         pop0[p]       = 1'b0;
         pop1[p]       = 1'b0;
         state_nxt[p]  = state[p];
         credit_nxt[p] = credit[p];
         if (!reset && !stall[p]) begin
            case (state[p])
               IDLE: begin
                  if (!empty0[p]) begin
                     pop0[p]       = 1'b1;
                     state_nxt[p]  = OWN_VC0;
                     credit_nxt[p] = 4'd1;
                  end else if (!empty1[p]) begin
                     pop1[p]       = 1'b1;
                     state_nxt[p]  = OWN_VC1;
                     credit_nxt[p] = 4'd1;
                  end
               end
               OWN_VC0, OWN_VC1: begin
                  if (!emp_c[p] && (credit[p] < wgt_c[p])) begin
                     // continue the current burst
                     {pop1[p], pop0[p]} = own1[p] ? 2'b10 : 2'b01;
                     credit_nxt[p]      = credit[p] + 4'd1;
                  end else if (!emp_o[p]) begin
                     // hand ownership to the other VC
                     {pop1[p], pop0[p]} = own1[p] ? 2'b01 : 2'b10;
                     state_nxt[p]       = own1[p] ? OWN_VC0 : OWN_VC1;
                     credit_nxt[p]      = 4'd1;
                  end else if (!emp_c[p]) begin
                     // other VC idle: owner starts a fresh burst
                     {pop1[p], pop0[p]} = own1[p] ? 2'b10 : 2'b01;
                     credit_nxt[p]      = 4'd1;
                  end else begin
                     state_nxt[p]  = IDLE;
                     credit_nxt[p] = 4'd0;
                  end
               end
               default: begin
                  state_nxt[p]  = IDLE;
                  credit_nxt[p] = 4'd0;
               end
            endcase
         end
      end
   end

   // State, output stage and sticky error. The FIFO presents data one cycle
   // after the pop (pend stage); it is captured into the output register on
   // that cycle, giving a two-cycle pop-to-output latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned p = 0; p < 2; p++) begin
            state[p]  <= IDLE;
            credit[p] <= 4'd0;
            pend[p]   <= 1'b0;
            vc_d[p]   <= 1'b0;
            out_v[p]  <= 1'b0;
            out_q[p]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int unsigned p = 0; p < 2; p++) begin
            state[p]  <= state_nxt[p];
            credit[p] <= credit_nxt[p];
            pend[p]   <= pop0[p] | pop1[p];
            vc_d[p]   <= pop1[p];
            out_v[p]  <= pend[p];
            if (pend[p]) begin
               out_q[p] <= {vc_d[p], vc_d[p] ? data1[p] : data0[p]};
               // word is forwarded regardless; the error only flags it
               if (!(vc_d[p] ? fvalid1[p] : fvalid0[p])) begin
                  err_q <= 1'b1;
               end
            end
         end
      end
   end

   assign pop_vc0_p0   = pop0[0];
   assign pop_vc1_p0   = pop1[0];
   assign pop_vc0_p1   = pop0[1];
   assign pop_vc1_p1   = pop1[1];
   assign out_p0       = out_q[0];
   assign out_p1       = out_q[1];
   assign out_valid_p0 = out_v[0];
   assign out_valid_p1 = out_v[1];
   assign sched_err    = err_q;

`ifdef SCHED_GRANT_CNT_EN
   logic [3:0] pop_all;
   logic [7:0] cnt [4];

   // Field order matches grant_cnt: {vc1_p1, vc0_p1, vc1_p0, vc0_p0}.
   assign pop_all = {pop1[1], pop0[1], pop1[0], pop0[0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (pop_all[i] && (cnt[i] != '1)) begin
               cnt[i] <= cnt[i] + 8'd1;
            end
         end
      end
   end

   assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_vc_port_scheduler.sv
// Self-checking bench for vc_port_scheduler. Four behavioural FIFOs feed the
// design; a reference model applies the scheduling rules per cycle and
// predicts pops, tagged output words, sched_err and grant counters.
// FIFO index f = 2*port + vc.

module tb_vc_port_scheduler;
   localparam int unsigned W0 = 3;
   localparam int unsigned W1 = 1;
   localparam int unsigned D  = 512;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic [1:0] stall = '0;
   logic [3:0] kill  = '0;

   // behavioural FIFOs
   logic [4:0] mem [4][D];
   int         head [4];
   int         tail [4] = '{default: 0};
   logic [3:0] vld_r;
   logic [4:0] dout_r [4];
   logic [3:0] empty, fvalid, pop;

   logic [5:0]  out_p0, out_p1;
   logic        out_valid_p0, out_valid_p1, sched_err;
   logic [31:0] grant_cnt;

   int checks = 0;
   int passes = 0;

   // reference model state
   int         m_own [2] = '{-1, -1};
   int         m_run [2] = '{0, 0};
   bit         m_pend_v [2] = '{0, 0};
   int         m_pend_vc [2] = '{0, 0};
   logic [4:0] m_pend_d [2];
   bit         m_ov [2] = '{0, 0};
   logic [5:0] m_o [2] = '{6'd0, 6'd0};
   bit         m_err = 1'b0;
   int         m_cnt [4] = '{default: 0};

   logic [50:0] exp_vec;
   logic [50:0] obs;

   always #5 clk = ~clk;

   always_comb begin
      for (int f = 0; f < 4; f++) begin
         empty[f]  = (head[f] == tail[f]);
         fvalid[f] = vld_r[f] & ~kill[f];
      end
   end

   always @(posedge clk) begin
      for (int f = 0; f < 4; f++) begin
         if (reset) begin
            head[f]  <= tail[f];
            vld_r[f] <= 1'b0;
         end else if (pop[f] && head[f] != tail[f]) begin
            dout_r[f] <= mem[f][head[f] % D];
            head[f]   <= head[f] + 1;
            vld_r[f]  <= 1'b1;
         end else begin
            vld_r[f] <= 1'b0;
         end
      end
   end

   assign obs = {pop, out_valid_p1, out_valid_p1 ? out_p1 : 6'd0,
                 out_valid_p0, out_valid_p0 ? out_p0 : 6'd0, sched_err, grant_cnt};

   vc_port_scheduler #(.W0(W0), .W1(W1)) dut (
      .clk           (clk),
      .reset         (reset),
      .empty_vc0_p0  (empty[0]),
      .empty_vc1_p0  (empty[1]),
      .empty_vc0_p1  (empty[2]),
      .empty_vc1_p1  (empty[3]),
      .fifo_vc0_p0   (dout_r[0]),
      .fifo_vc1_p0   (dout_r[1]),
      .fifo_vc0_p1   (dout_r[2]),
      .fifo_vc1_p1   (dout_r[3]),
      .fvalid_vc0_p0 (fvalid[0]),
      .fvalid_vc1_p0 (fvalid[1]),
      .fvalid_vc0_p1 (fvalid[2]),
      .fvalid_vc1_p1 (fvalid[3]),
      .stall_p0      (stall[0]),
      .stall_p1      (stall[1]),
      .pop_vc0_p0    (pop[0]),
      .pop_vc1_p0    (pop[1]),
      .pop_vc0_p1    (pop[2]),
      .pop_vc1_p1    (pop[3]),
      .out_p0        (out_p0),
      .out_p1        (out_p1),
      .out_valid_p0  (out_valid_p0),
      .out_valid_p1  (out_valid_p1),
      .sched_err     (sched_err),
      .grant_cnt     (grant_cnt)
   );

   task automatic load(input int f, input int n);
      for (int i = 0; i < n; i++) begin
         mem[f][tail[f] % D] = 5'($urandom);
         tail[f] = tail[f] + 1;
      end
   endtask

   // Reference model: called once per cycle after inputs settle. Produces
   // exp_vec for this cycle, then advances the model to the next cycle.
   task automatic predict();
      int          vc, c, o, lim, f;
      logic [3:0]  p_pop;
      logic [31:0] cnt_vec;
      logic [46:0] snap;
      cnt_vec = '0;
`ifdef SCHED_GRANT_CNT_EN
      for (int i = 0; i < 4; i++) cnt_vec[8*i +: 8] = 8'(m_cnt[i]);
`endif
      snap = {m_ov[1], m_ov[1] ? m_o[1] : 6'd0, m_ov[0], m_ov[0] ? m_o[0] : 6'd0,
              m_err, cnt_vec};
      p_pop = '0;
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            m_own[p] = -1; m_run[p] = 0; m_pend_v[p] = 0; m_ov[p] = 0; m_o[p] = '0;
         end
         m_err = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (m_pend_v[p] && !fvalid[2*p + m_pend_vc[p]]) m_err = 1;
            m_ov[p] = m_pend_v[p];
            if (m_pend_v[p]) m_o[p] = {m_pend_vc[p] == 1, m_pend_d[p]};
         end
         for (int p = 0; p < 2; p++) begin
            vc = -1;
            if (!stall[p]) begin
               if (m_own[p] < 0) begin
                  if (!empty[2*p]) vc = 0;
                  else if (!empty[2*p+1]) vc = 1;
                  if (vc >= 0) begin m_own[p] = vc; m_run[p] = 1; end
               end else begin
                  c   = m_own[p];
                  o   = 1 - c;
                  lim = (c == 0) ? int'(W0) : int'(W1);
                  if (!empty[2*p+c] && m_run[p] < lim) begin
                     vc = c; m_run[p]++;
                  end else if (!empty[2*p+o]) begin
                     vc = o; m_own[p] = o; m_run[p] = 1;
                  end else if (!empty[2*p+c]) begin
                     vc = c; m_run[p] = 1;
                  end else begin
                     m_own[p] = -1; m_run[p] = 0;
                  end
               end
            end
            m_pend_v[p] = (vc >= 0);
            if (vc >= 0) begin
               f = 2*p + vc;
               p_pop[f] = 1'b1;
               m_pend_vc[p] = vc;
               m_pend_d[p]  = mem[f][head[f] % D];
               if (m_cnt[f] < 255) m_cnt[f]++;
            end
         end
      end
      exp_vec = {p_pop, snap};
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL reset cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
      end
      checks++;
      if ({out_p1, out_p0, out_valid_p1, out_valid_p0, sched_err, grant_cnt} !== 47'd0)
         $display("FAIL reset_regs got %h %h %b %b %b %h expected all zero",
                  out_p1, out_p0, out_valid_p1, out_valid_p0, sched_err, grant_cnt);
      else passes++;
      @(negedge clk); reset = 1'b0; #1; predict();
      checks++;
      if (obs !== exp_vec) $display("FAIL reset_release got %h expected %h", obs, exp_vec);
      else passes++;
   endtask

   task automatic test_wrr();
      logic [7:0] ord = '0, tags = '0;
      int no = 0, nt = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 0) begin load(0, 6); load(1, 2); end
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL wrr cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
         if (pop[0] || pop[1]) begin ord = {ord[6:0], pop[1]}; no++; end
         if (out_valid_p0) begin tags = {tags[6:0], out_p0[5]}; nt++; end
      end
      checks++;
      if (no != 8 || ord !== 8'b00010001) $display("FAIL wrr_order got %b (%0d) expected 00010001 (8)", ord, no);
      else passes++;
      checks++;
      if (nt != 8 || tags !== 8'b00010001) $display("FAIL wrr_tags got %b (%0d) expected 00010001 (8)", tags, nt);
      else passes++;
   endtask

   task automatic test_vc1_only();
      int np = 0, nv = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) load(3, 4);
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL vc1_only cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
         if (pop[3]) np++;
         if (out_valid_p1) nv++;
      end
      checks++;
      if (np != 4 || nv != 4) $display("FAIL vc1_only_counts got pops %0d valid %0d expected 4 4", np, nv);
      else passes++;
   endtask

   task automatic test_stall();
      int nwin = 0, nstall_pop = 0, ntot = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (i == 0) begin load(0, 20); load(1, 5); end
         stall[0] = (i >= 2 && i <= 4);
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL stall cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
         if (i >= 2 && i <= 5 && out_valid_p0) nwin++;
         if (stall[0] && (pop[0] || pop[1])) nstall_pop++;
         if (pop[0] || pop[1]) ntot++;
         if (i == 5 || i == 6) begin
            checks++;
            if (pop[1:0] !== ((i == 5) ? 2'b01 : 2'b10))
               $display("FAIL stall_resume cyc %0d got %b expected %b", i, pop[1:0], (i == 5) ? 2'b01 : 2'b10);
            else passes++;
         end
      end
      checks++;
      if (nwin != 2 || nstall_pop != 0 || ntot != 25)
         $display("FAIL stall_counts got win %0d stallpops %0d total %0d expected 2 0 25", nwin, nstall_pop, ntot);
      else passes++;
   endtask

   task automatic test_single();
      int np = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) load(0, 1);
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL single cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
         if (pop[0] || pop[1]) np++;
      end
      checks++;
      if (np != 1) $display("FAIL single_pops got %0d expected 1", np);
      else passes++;
   endtask

   task automatic test_err();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i == 0) load(2, 2);
         kill[2] = (i == 1);
         reset   = (i == 6 || i == 7);
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL err cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
         if (i == 5 || i == 9) begin
            checks++;
            if (sched_err !== (i == 5))
               $display("FAIL err_sticky cyc %0d got %b expected %b", i, sched_err, i == 5);
            else passes++;
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 440; i++) begin
         @(negedge clk);
         reset = (i == 200 || i == 201);
         if (i < 400) begin
            for (int p = 0; p < 2; p++) stall[p] = ($urandom_range(0, 4) == 0);
            if (!reset)
               for (int f = 0; f < 4; f++)
                  if ($urandom_range(0, 7) == 0 && tail[f] - head[f] < 100)
                     load(f, int'($urandom_range(1, 4)));
         end else begin
            stall = '0;
         end
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL random cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
      end
   endtask

   task automatic test_grant_cnt();
      for (int i = 0; i < 308; i++) begin
         @(negedge clk);
         reset = (i < 2);
         if (i == 2) load(0, 300);
         #1; predict();
         checks++;
         if (obs !== exp_vec) $display("FAIL grant_cnt cyc %0d got %h expected %h", i, obs, exp_vec);
         else passes++;
      end
      checks++;
`ifdef SCHED_GRANT_CNT_EN
      if (grant_cnt !== 32'h000000FF) $display("FAIL grant_cnt_sat got %h expected 000000ff", grant_cnt);
      else passes++;
`else
      if (grant_cnt !== 32'h0) $display("FAIL grant_cnt_off got %h expected 00000000", grant_cnt);
      else passes++;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_wrr();
      test_vc1_only();
      test_stall();
      test_single();
      test_err();
      test_random();
      test_grant_cnt();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
